unidade_controle_multiciclo: RTL and testbench
==============================================

Name: unidade_controle_multiciclo

Overview:
Multicycle Moore control FSM for the MIPS-subset datapath. It sequences fetch, decode, execute, memory and writeback over the shared ALU, register file, memory port and 16→32 immediate extender. It selects sign extension or zero extension per instruction. It handshakes with a variable-latency memory through mem_ready. It sits beside the datapath top level and drives every mux select and write enable.

Parameters:
None. All encodings below are fixed.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
opcode  in  6  IR[31:26]; valid from DECODE onward
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current read or write this cycle
pc_write  out  1  PC load enable
ir_write  out  1  IR load enable
mem_read  out  1  memory read request; held until mem_ready
mem_write  out  1  memory write request; held until mem_ready
i_or_d  out  1  0 = address from PC, 1 = address from ALUOut
reg_write  out  1  register file write enable
reg_dst  out  1  0 = rt, 1 = rd
mem_to_reg  out  1  0 = ALUOut, 1 = MDR
alu_src_a  out  1  0 = PC, 1 = rs
alu_src_b  out  2  00 = rt, 01 = const 4, 10 = ext, 11 = ext<<2
alu_ctrl  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT
pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
ext_zero  out  1  extender mode: 1 = zero-extend, 0 = sign-extend
estado  out  4  current state code, for debug
erro  out  1  illegal instruction detected; sticky

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- While reset is high: state = IDLE and opcode/funct latches = 0. All outputs are 0, including erro.
- Outputs are pure decode of the state register, the latched opcode/funct, zero and mem_ready. There are no extra pipeline registers on outputs.
- opcode and funct are latched on the DECODE→next transition. Execute-phase decode uses only the latched copies.
- State codes:
  IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_RD 4, MEM_WB 5, MEM_WR 6, R_EXEC 7, R_WB 8, BRANCH 9, JUMP 10, I_EXEC 11, I_WB 12, ERRO 13.
- Transitions:
  - IDLE→FETCH unconditionally.
  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, ADD, pc_source=00. Stays in FETCH while mem_ready=0. In the mem_ready=1 cycle, ir_write=1 and pc_write=1, then go to DECODE.
  - DECODE: alu_src_a=0, alu_src_b=11, ADD, ext_zero=0 (branch target into ALUOut).
    - Next state by opcode: 0x00 → R_EXEC; 0x23/0x2B → MEM_ADDR; 0x04/0x05 → BRANCH; 0x02 → JUMP; 0x08/0x0C/0x0D/0x0A → I_EXEC.
    - Any other opcode → ERRO.
    - R_EXEC with funct outside {0x20, 0x22, 0x24, 0x25, 0x2A} → ERRO.
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD, ext_zero=0. lw → MEM_RD; sw → MEM_WR.
  - MEM_RD: mem_read=1, i_or_d=1. Waits for mem_ready, then → MEM_WB.
  - MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1, then → FETCH.
  - MEM_WR: mem_write=1, i_or_d=1. Waits for mem_ready, then → FETCH.
  - R_EXEC: alu_src_a=1, alu_src_b=00. alu_ctrl from funct: 20 ADD, 22 SUB, 24 AND, 25 OR, 2A SLT. Then → R_WB.
  - R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, then → FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_source=01. pc_write = (beq & zero) | (bne & ~zero). Then → FETCH.
  - JUMP: pc_source=10, pc_write=1, then → FETCH.
  - I_EXEC: alu_src_a=1, alu_src_b=10.
    - addi: ADD, ext_zero=0. andi: AND, ext_zero=1. ori: OR, ext_zero=1. slti: SLT, ext_zero=0.
    - Then → I_WB.
  - I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, then → FETCH.
  - ERRO: erro=1; all enables 0. Absorbing until reset.
- Latency with mem_ready already high (cycles from FETCH entry back to FETCH): lw 5, sw 4, R 4, I 4, beq/bne 3, j 3. Each cycle mem_ready stays low adds one cycle to a memory state.
- ext_zero is 0 in every state except I_EXEC for andi/ori.
- mem_read and mem_write are never asserted together.
- Reset mid-operation, including mid-wait: immediate return to IDLE with all outputs 0. A pending memory request is dropped.

Test Plan:
- Reset then release, mem_ready=1, IR=lw (0x23) → estado sequence 0,1,2,3,4,5,1. reg_write=1 with mem_to_reg=1 only in state 5.
- FETCH with mem_ready low for 3 cycles → mem_read=1 for 4 cycles. ir_write and pc_write pulse exactly once, in the 4th cycle.
- andi (0x0C) → ext_zero=1 and alu_ctrl=0000 in I_EXEC. addi (0x08) → ext_zero=0 and ADD.
- beq with zero=1 → pc_write=1, pc_source=01 in BRANCH. bne with zero=1 → pc_write=0. Both return to FETCH after 3 cycles.
- opcode 0x3F, or R-type with funct 0x01 → ERRO (13), erro=1 and held. No further mem_read. Asserting reset clears erro and enters IDLE.
- Assert reset asynchronously mid-MEM_WR wait → mem_write drops the same instant, without waiting for a clock edge. estado=0.

Source files
------------

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle Moore control unit for the MIPS-subset datapath.
// The state register and the opcode/funct copies are the only storage.
// Every output is decoded from them plus zero and mem_ready, so an
// asynchronous reset clears every output at once, with no clock edge.
module unidade_controle_multiciclo (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_ctrl,
  output logic [1:0] pc_source,
  output logic       ext_zero,
  output logic [3:0] estado,
  output logic       erro
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WB   = 4'd5,
    MEM_WR   = 4'd6,
    R_EXEC   = 4'd7,
    R_WB     = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
    I_EXEC   = 4'd11,
    I_WB     = 4'd12,
    ERRO     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  state_t     state;
  logic [5:0] opcode_q;
  logic [5:0] funct_q;
  logic       funct_ok;

  assign funct_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                    (funct == FN_OR)  || (funct == FN_SLT);

  // State sequencing; opcode/funct are captured as DECODE hands off
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      opcode_q <= 6'h00;
      funct_q  <= 6'h00;
    end else begin
      case (state)
        IDLE:   state <= FETCH;
        FETCH:  if (mem_ready) state <= DECODE;
        DECODE: begin
          opcode_q <= opcode;
          funct_q  <= funct;
          case (opcode)
            OP_RTYPE:                         state <= funct_ok ? R_EXEC : ERRO;
            OP_LW, OP_SW:                     state <= MEM_ADDR;
            OP_BEQ, OP_BNE:                   state <= BRANCH;
            OP_J:                             state <= JUMP;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state <= I_EXEC;
            default:                          state <= ERRO;
          endcase
        end
        MEM_ADDR: state <= (opcode_q == OP_LW) ? MEM_RD : MEM_WR;
        MEM_RD:   if (mem_ready) state <= MEM_WB;
        MEM_WB:   state <= FETCH;
        MEM_WR:   if (mem_ready) state <= FETCH;
        R_EXEC:   state <= R_WB;
        R_WB:     state <= FETCH;
        BRANCH:   state <= FETCH;
        JUMP:     state <= FETCH;
        I_EXEC:   state <= I_WB;
        I_WB:     state <= FETCH;
        ERRO:     state <= ERRO;
        default:  state <= IDLE;
      endcase
    end
  end

  // Datapath control decoded from the current state and latched instruction
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_ctrl   = ALU_AND;
    pc_source  = 2'b00;
    ext_zero   = 1'b0;
    erro       = 1'b0;
    estado     = state;
    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_ctrl  = ALU_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        alu_ctrl  = ALU_ADD;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl  = ALU_ADD;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        case (funct_q)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: alu_ctrl = ALU_AND;
        endcase
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl  = ALU_SUB;
        pc_source = 2'b01;
        pc_write  = ((opcode_q == OP_BEQ) && zero) || ((opcode_q == OP_BNE) && !zero);
      end
      JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
      end
      I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (opcode_q)
          OP_ANDI: begin alu_ctrl = ALU_AND; ext_zero = 1'b1; end
          OP_ORI:  begin alu_ctrl = ALU_OR;  ext_zero = 1'b1; end
          OP_SLTI: alu_ctrl = ALU_SLT;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      I_WB: begin
        reg_write = 1'b1;
      end
      ERRO: begin
        erro = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Directed bench for the multicycle control unit: instruction walks,
// memory wait states, branch decisions, illegal instructions and
// asynchronous reset during a memory wait.
module tb_unidade_controle_multiciclo;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, ir_write, mem_read, mem_write, i_or_d;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_ctrl;
  logic [1:0] pc_source;
  logic       ext_zero;
  logic [3:0] estado;
  logic       erro;

  int checks   = 0;
  int failures = 0;
  int readCycles;
  int irPulses;
  int pcPulses;

  unidade_controle_multiciclo dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .i_or_d     (i_or_d),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_ctrl   (alu_ctrl),
    .pc_source  (pc_source),
    .ext_zero   (ext_zero),
    .estado     (estado),
    .erro       (erro)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input logic rdy);
    opcode    = op;
    funct     = fn;
    zero      = z;
    mem_ready = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance to 2 time units after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(6'h23, 6'h00, 1'b0, 1'b1);
    #3;
    checkOutput("reset_estado", 32'(estado), 32'd0);
    checkOutput("reset_mem_read", 32'(mem_read), 32'd0);
    checkOutput("reset_erro", 32'(erro), 32'd0);
    checkOutput("reset_alu_src_b", 32'(alu_src_b), 32'd0);
    #9 reset = 1'b0;

    // lw with memory always ready: 0,1,2,3,4,5,1
    cyc(); #1;
    checkOutput("lw_fetch_estado", 32'(estado), 32'd1);
    checkOutput("lw_fetch_ir_write", 32'(ir_write), 32'd1);
    checkOutput("lw_fetch_pc_write", 32'(pc_write), 32'd1);
    checkOutput("lw_fetch_alu_src_b", 32'(alu_src_b), 32'd1);
    cyc(); #1;
    checkOutput("lw_decode_estado", 32'(estado), 32'd2);
    checkOutput("lw_decode_alu_src_b", 32'(alu_src_b), 32'd3);
    checkOutput("lw_decode_mem_read", 32'(mem_read), 32'd0);
    cyc(); #1;
    checkOutput("lw_addr_estado", 32'(estado), 32'd3);
    checkOutput("lw_addr_alu_src_a", 32'(alu_src_a), 32'd1);
    checkOutput("lw_addr_alu_src_b", 32'(alu_src_b), 32'd2);
    checkOutput("lw_addr_alu_ctrl", 32'(alu_ctrl), 32'd2);
    cyc(); #1;
    checkOutput("lw_rd_estado", 32'(estado), 32'd4);
    checkOutput("lw_rd_mem_read", 32'(mem_read), 32'd1);
    checkOutput("lw_rd_i_or_d", 32'(i_or_d), 32'd1);
    checkOutput("lw_rd_reg_write", 32'(reg_write), 32'd0);
    cyc(); #1;
    checkOutput("lw_wb_estado", 32'(estado), 32'd5);
    checkOutput("lw_wb_reg_write", 32'(reg_write), 32'd1);
    checkOutput("lw_wb_mem_to_reg", 32'(mem_to_reg), 32'd1);
    checkOutput("lw_wb_reg_dst", 32'(reg_dst), 32'd0);
    // Hold memory off for the next fetch and queue andi
    applyStimulus(6'h0C, 6'h00, 1'b0, 1'b0);

    // FETCH with three wait cycles
    readCycles = 0;
    irPulses   = 0;
    pcPulses   = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (i == 3) mem_ready = 1'b1;
      #1;
      checkOutput("wait_fetch_estado", 32'(estado), 32'd1);
      readCycles += int'(mem_read);
      irPulses   += int'(ir_write);
      pcPulses   += int'(pc_write);
    end
    checkOutput("wait_read_cycles", 32'(readCycles), 32'd4);
    checkOutput("wait_ir_pulses", 32'(irPulses), 32'd1);
    checkOutput("wait_pc_pulses", 32'(pcPulses), 32'd1);
    checkOutput("wait_last_ir_write", 32'(ir_write), 32'd1);

    // andi: zero-extend, AND
    cyc(); #1;
    checkOutput("andi_decode_estado", 32'(estado), 32'd2);
    checkOutput("andi_decode_ext_zero", 32'(ext_zero), 32'd0);
    cyc(); #1;
    checkOutput("andi_exec_estado", 32'(estado), 32'd11);
    checkOutput("andi_exec_ext_zero", 32'(ext_zero), 32'd1);
    checkOutput("andi_exec_alu_ctrl", 32'(alu_ctrl), 32'd0);
    cyc(); #1;
    checkOutput("andi_wb_estado", 32'(estado), 32'd12);
    checkOutput("andi_wb_reg_write", 32'(reg_write), 32'd1);
    checkOutput("andi_wb_ext_zero", 32'(ext_zero), 32'd0);
    applyStimulus(6'h08, 6'h00, 1'b0, 1'b1);

    // addi: sign-extend, ADD
    cyc(); #1;
    checkOutput("addi_fetch_estado", 32'(estado), 32'd1);
    cyc(); cyc(); #1;
    checkOutput("addi_exec_estado", 32'(estado), 32'd11);
    checkOutput("addi_exec_ext_zero", 32'(ext_zero), 32'd0);
    checkOutput("addi_exec_alu_ctrl", 32'(alu_ctrl), 32'd2);
    cyc();
    applyStimulus(6'h04, 6'h00, 1'b1, 1'b1);

    // beq taken
    cyc(); #1;
    checkOutput("beq_fetch_estado", 32'(estado), 32'd1);
    cyc(); cyc(); #1;
    checkOutput("beq_branch_estado", 32'(estado), 32'd9);
    checkOutput("beq_pc_write", 32'(pc_write), 32'd1);
    checkOutput("beq_pc_source", 32'(pc_source), 32'd1);
    checkOutput("beq_alu_ctrl", 32'(alu_ctrl), 32'd6);
    applyStimulus(6'h05, 6'h00, 1'b1, 1'b1);

    // bne not taken while zero is high
    cyc(); #1;
    checkOutput("beq_return_estado", 32'(estado), 32'd1);
    cyc(); cyc(); #1;
    checkOutput("bne_branch_estado", 32'(estado), 32'd9);
    checkOutput("bne_pc_write", 32'(pc_write), 32'd0);
    zero = 1'b0;
    #1;
    checkOutput("bne_nz_pc_write", 32'(pc_write), 32'd1);
    applyStimulus(6'h00, 6'h22, 1'b0, 1'b1);

    // R-type sub
    cyc(); #1;
    checkOutput("bne_return_estado", 32'(estado), 32'd1);
    cyc(); cyc(); #1;
    checkOutput("sub_exec_estado", 32'(estado), 32'd7);
    checkOutput("sub_alu_ctrl", 32'(alu_ctrl), 32'd6);
    checkOutput("sub_alu_src_b", 32'(alu_src_b), 32'd0);
    cyc(); #1;
    checkOutput("sub_wb_estado", 32'(estado), 32'd8);
    checkOutput("sub_wb_reg_dst", 32'(reg_dst), 32'd1);
    checkOutput("sub_wb_reg_write", 32'(reg_write), 32'd1);
    applyStimulus(6'h2B, 6'h00, 1'b0, 1'b1);

    // sw stalled in MEM_WR, then reset asynchronously
    cyc(); cyc(); cyc(); #1;
    checkOutput("sw_addr_estado", 32'(estado), 32'd3);
    mem_ready = 1'b0;
    cyc(); #1;
    checkOutput("sw_wr_estado", 32'(estado), 32'd6);
    checkOutput("sw_wr_mem_write", 32'(mem_write), 32'd1);
    checkOutput("sw_wr_mem_read", 32'(mem_read), 32'd0);
    cyc(); #1;
    checkOutput("sw_wait_estado", 32'(estado), 32'd6);
    #1 reset = 1'b1;
    #1;
    checkOutput("async_mem_write", 32'(mem_write), 32'd0);
    checkOutput("async_estado", 32'(estado), 32'd0);
    #2 reset = 1'b0;
    applyStimulus(6'h3F, 6'h00, 1'b0, 1'b1);

    // Illegal opcode lands in ERRO and stays there
    cyc(); #1;
    checkOutput("illop_fetch_estado", 32'(estado), 32'd1);
    cyc(); cyc(); #1;
    checkOutput("illop_estado", 32'(estado), 32'd13);
    checkOutput("illop_erro", 32'(erro), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      checkOutput("illop_held_estado", 32'(estado), 32'd13);
      checkOutput("illop_held_erro", 32'(erro), 32'd1);
      checkOutput("illop_held_mem_read", 32'(mem_read), 32'd0);
    end
    #1 reset = 1'b1;
    #1;
    checkOutput("illop_reset_erro", 32'(erro), 32'd0);
    checkOutput("illop_reset_estado", 32'(estado), 32'd0);
    #2 reset = 1'b0;
    applyStimulus(6'h00, 6'h01, 1'b0, 1'b1);

    // R-type with an unsupported funct
    cyc(); cyc(); cyc(); #1;
    checkOutput("badfn_estado", 32'(estado), 32'd13);
    checkOutput("badfn_erro", 32'(erro), 32'd1);
    cyc(); #1;
    checkOutput("badfn_held_mem_read", 32'(mem_read), 32'd0);
    checkOutput("badfn_held_erro", 32'(erro), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
